// File: rtl/chacha20_stream_ctrl.sv
// chacha20_stream_ctrl: sequences ChaCha20 block-function runs and downstream keystream handshakes per 64-byte block.
// Optional block-function watchdog is enabled by defining CHACHA_CTRL_WDOG_EN.
module chacha20_stream_ctrl #(
  parameter int CTR_W = 32,
  parameter int LEN_W = 32,
  parameter int WDOG_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [CTR_W-1:0] init_counter,
  output logic             bf_start,
  output logic [CTR_W-1:0] bf_counter,
  input  logic             bf_done,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [6:0]       byte_count,
  output logic             last_block,
  output logic             busy,
  output logic             done,
  output logic             err_ovf
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, WAIT_BF = 3'd2, HOLD = 3'd3, DONE = 3'd4, ERR = 3'd5;
  logic [2:0]     state;
  logic [LEN_W:0] blocks_left;
  logic [5:0]     tail;
  logic           take, wd_exp;
  assign take       = start && (state == IDLE || state == ERR);
  assign bf_start   = state == START;
  assign ks_valid   = state == HOLD;
  assign done       = state == DONE;
  assign busy       = state != IDLE && state != ERR;
  assign last_block = ks_valid && blocks_left == (LEN_W+1)'(1);
  // a zero tail means the final block is a full 64 bytes
  assign byte_count = !ks_valid ? 7'd0 : (last_block && tail != 6'd0) ? {1'b0, tail} : 7'd64;
`ifdef CHACHA_CTRL_WDOG_EN
  localparam int WD_W = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;
  logic [WD_W-1:0] wd;
  assign wd_exp = state == WAIT_BF && wd == WD_W'(WDOG_CYCLES - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) wd <= '0;
    else wd <= (state == WAIT_BF) ? wd + WD_W'(1) : '0;
`else
  assign wd_exp = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bf_counter  <= '0;
      blocks_left <= '0;
      tail        <= '0;
      err_ovf     <= 1'b0;
    end else if (take) begin
      tail        <= msg_len[5:0];
      bf_counter  <= init_counter;
      blocks_left <= ({1'b0, msg_len} + (LEN_W+1)'(63)) >> 6;
      err_ovf     <= 1'b0;
      state       <= (msg_len == '0) ? DONE : START;
    end else begin
      case (state)
        START: state <= WAIT_BF;
        WAIT_BF:
          if (bf_done) state <= HOLD;
          else if (wd_exp) begin
            err_ovf <= 1'b1;
            state   <= ERR;
          end
        HOLD:
          if (ks_ready) begin
            blocks_left <= blocks_left - (LEN_W+1)'(1);
            if (last_block) state <= DONE;
            else if (&bf_counter) begin
              err_ovf <= 1'b1;
              state   <= ERR;
            end else begin
              bf_counter <= bf_counter + CTR_W'(1);
              state      <= START;
            end
          end
        DONE: state <= IDLE;
        IDLE, ERR: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// tb_chacha20_stream_ctrl: randomized message runs checked against a per-message block-list model.
module tb_chacha20_stream_ctrl;
  localparam int CTR_W = 32, LEN_W = 32, WD = 16;
  logic clk = 0, rst = 0, start = 0, bf_done = 0, ks_ready = 0;
  logic [LEN_W-1:0] msg_len = '0;
  logic [CTR_W-1:0] init_counter = '0;
  logic bf_start, ks_valid, last_block, busy, done, err_ovf;
  logic [CTR_W-1:0] bf_counter;
  logic [6:0] byte_count;
  int n_chk = 0, n_pass = 0, starts = 0, dones = 0;

  always #5 clk = ~clk;

  chacha20_stream_ctrl #(.CTR_W(CTR_W), .LEN_W(LEN_W), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .init_counter(init_counter),
    .bf_start(bf_start), .bf_counter(bf_counter), .bf_done(bf_done), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .byte_count(byte_count), .last_block(last_block), .busy(busy),
    .done(done), .err_ovf(err_ovf)
  );

  always @(posedge clk) begin
    if (bf_start) starts++;
    if (done) dones++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_start(input longint len, input longint ctr);
    @(negedge clk);
    msg_len = LEN_W'(len);
    init_counter = CTR_W'(ctr);
    start = 1;
    @(negedge clk);
    start = 0;
    msg_len = LEN_W'($urandom);
  endtask

  // Model: a message is ceil(len/64) blocks numbered from ctr; counters past all-ones are never issued.
  task automatic run_msg(input longint len, input longint ctr, input int lat, input int stall);
    longint n = (len + 63) / 64;
    longint room = 64'h1_0000_0000 - ctr;
    longint nb = (n < room) ? n : room;
    bit ovf = n > room;
    int s0 = starts, d0 = dones;
    logic [CTR_W-1:0] c_hold;
    logic [6:0] b_hold;
    send_start(len, ctr);
    check("err_clear_on_start", err_ovf, 0);
    for (longint i = 0; i < nb; i++) begin
      bit lastb = (i == n - 1);
      longint ebc = (lastb && len % 64 != 0) ? len % 64 : 64;
      check("bf_start", bf_start, 1);
      check("bf_counter", bf_counter, ctr + i);
      @(negedge clk);
      ks_ready = 1'($urandom);
      if (i == 0) begin
        start = 1;
        init_counter = CTR_W'($urandom);
      end
      repeat (lat) @(negedge clk);
      start = 0;
      ks_ready = 0;
      check("ks_valid_before_bf_done", ks_valid, 0);
      bf_done = 1;
      @(negedge clk);
      bf_done = 0;
      check("ks_valid", ks_valid, 1);
      check("byte_count", byte_count, ebc);
      check("last_block", last_block, lastb);
      check("bf_counter_hold", bf_counter, ctr + i);
      c_hold = bf_counter;
      b_hold = byte_count;
      repeat (stall) begin
        bf_done = 1'($urandom);
        @(negedge clk);
      end
      bf_done = 0;
      if (stall > 0) check("stall_stable", {ks_valid, bf_counter, byte_count, bf_start}, {1'b1, c_hold, b_hold, 1'b0});
      ks_ready = 1;
      @(negedge clk);
      ks_ready = 0;
    end
    if (ovf) begin
      check("err_ovf", err_ovf, 1);
      check("busy_err", busy, 0);
      repeat (4) @(negedge clk);
      check("no_more_bf_start", starts - s0, nb);
      check("no_done_on_err", dones - d0, 0);
    end else begin
      check("done", done, 1);
      check("busy_done", busy, 1);
      @(negedge clk);
      check("busy_idle", busy, 0);
      check("done_count", dones - d0, 1);
      check("bf_start_count", starts - s0, nb);
    end
  endtask

  initial begin
    int k;
    #1;
    check("reset_outputs", {bf_start, ks_valid, last_block, busy, done, err_ovf, byte_count, bf_counter}, 0);
    @(negedge clk);
    rst = 1;
    run_msg(64, 1, 10, 0);
    run_msg(150, 7, 3, 0);
    run_msg(0, 5, 0, 0);
    run_msg(200, 64'hFFFF_FFFF, 2, 1);
    run_msg(64, 5, 1, 20);
    run_msg(64'hFFFF_FFFF, 64'hFFFF_FFFE, 1, 0);
    for (int t = 0; t < 25; t++) begin
      longint len = ($urandom % 5 == 0) ? 0 : $urandom_range(1, 450);
      longint ctr = ($urandom % 4 == 0) ? 64'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      run_msg(len, ctr, $urandom_range(0, 6), $urandom_range(0, 4));
    end
    send_start(300, 3);
    @(negedge clk);
    k = dones;
    #2 rst = 0;
    #1;
    check("async_reset_outputs", {bf_start, ks_valid, last_block, busy, done, err_ovf, byte_count, bf_counter}, 0);
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", dones - k, 0);
    check("idle_after_reset", busy, 0);
    send_start(64, 9);
    @(negedge clk);
`ifdef CHACHA_CTRL_WDOG_EN
    k = 0;
    while (!err_ovf && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wdog_cycles", k, WD);
    check("wdog_busy", busy, 0);
`else
    repeat (1000) @(negedge clk);
    check("no_wdog_err", err_ovf, 0);
    check("no_wdog_busy", busy, 1);
    bf_done = 1;
    @(negedge clk);
    bf_done = 0;
    check("late_ks_valid", ks_valid, 1);
    ks_ready = 1;
    @(negedge clk);
    ks_ready = 0;
    check("late_done", done, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
